poc_fifo_ctrl: RTL
==================

Name: poc_fifo_ctrl

Overview:
Parametrised printer output controller: a CPU writes characters into a DEPTH-entry FIFO through a small register file, and the block drains the FIFO to a printer over a strobe/ready handshake.
Supports polling mode and level-threshold interrupt mode, with sticky error flags and a FIFO fill-level readback.
Sits between the CPU register bus and the printer port, replacing the single-byte, single-bit-register controller.

Parameters:
DATA_W, 8, printer/CPU data width (4..16)
DEPTH, 8, FIFO entries; power of two, >= 2
IRQ_LEVEL, 2, irq asserts when FIFO count <= IRQ_LEVEL (must be < DEPTH)
STROBE_CYC, 2, prn_strobe high time in clk cycles (>= 1)
TIMEOUT_CYC, 1024, handshake watchdog limit (used only with POC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_we  in  1  register write strobe, one cycle per access
cpu_re  in  1  register read strobe
cpu_addr  in  2  register select: 0 DATA, 1 CTRL, 2 STATUS, 3 LEVEL
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  registered read data
irq_n  out  1  interrupt request, active low, registered
prn_ready  in  1  printer idle/ready
prn_data  out  DATA_W  character to printer
prn_strobe  out  1  data-valid strobe to printer

Behaviour:
- Reset (asynchronous, active-low; clock clk): FIFO empty, mode=0, ovf=0, tmo=0, FSM IDLE, cpu_rdata=0, irq_n=1, prn_data=0, prn_strobe=0. Reset mid-transfer aborts the transfer; strobe drops immediately.
- Registers:
  - DATA write: pushes cpu_wdata. If FIFO full, data is dropped and ovf (sticky) is set. DATA read returns 0.
  - CTRL: bit0 mode (0 polling, 1 interrupt), R/W. bit1 flush, write-1, self-clearing, reads 0. bit2 write-1 clears ovf and tmo. Other bits ignored.
  - STATUS (read-only): bit0 empty, bit1 full, bit2 ovf, bit3 tmo, bit7 ready (= !full); other bits 0.
  - LEVEL: FIFO count, zero-extended (0..DEPTH).
- Read latency: cpu_rdata is valid the cycle after cpu_re and holds its value until the next read. If cpu_we and cpu_re are asserted together, the write is performed and cpu_rdata holds.
- FIFO:
  - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged. This is legal when full: the pop frees the slot, so the push is accepted and ovf is not set.
  - Flush zeroes count and pointers next cycle. A flush in the same cycle as a push discards that push. A transfer already in STROBE/WAIT completes.
- Printer FSM:
  - IDLE: if !empty && prn_ready, load prn_data from the head, pop, raise prn_strobe, go to STROBE.
  - STROBE: hold strobe for STROBE_CYC cycles total, then drop it and go to WAIT_BUSY.
  - WAIT_BUSY: wait for prn_ready=0, then go to WAIT_RDY.
  - WAIT_RDY: wait for prn_ready=1, then go to IDLE.
  - prn_data is held stable from load until the next load.
  - Minimum per-character period is STROBE_CYC+3 cycles.
- Interrupt:
  - irq_n = !(mode && FSM==IDLE && count<=IRQ_LEVEL), registered with 1-cycle latency.
  - Polling mode: irq_n is held at 1.
  - irq_n deasserts once the CPU refills above IRQ_LEVEL, or when mode is cleared.

Optional Feature:
POC_TIMEOUT_EN:
- Defined: a counter runs in WAIT_BUSY/WAIT_RDY and clears on every state change. On reaching TIMEOUT_CYC it forces IDLE and sets tmo (sticky).
  - While tmo=1 the FSM does not start new transfers.
  - In interrupt mode, tmo=1 also drives irq_n low regardless of count.
- Undefined: no counter; the FSM waits indefinitely; STATUS bit3 reads 0.

Test Plan:
- Reset, polling mode; write 0x41,0x42,0x43 to DATA; printer model drops ready 2 cycles after each strobe and raises it 5 cycles later -> three 2-cycle strobes with prn_data 0x41,0x42,0x43 in order; LEVEL reads 3→0; irq_n stays 1.
- Printer ready held 0; write 9 bytes (DEPTH=8) -> STATUS reads 0x06 (full, ovf, ready=0); 9th byte never printed. Write CTRL=0x04 -> STATUS 0x02.
- CTRL=0x01; FIFO count 3 → drains to 2 with FSM back in IDLE -> irq_n low within 1 cycle. CPU writes one byte (count 3) -> irq_n high next cycle.
- FIFO full and IDLE with prn_ready=1; DATA write in the same cycle as the pop -> count stays 8, ovf=0, written byte printed last.
- Flush (CTRL=0x02) during STROBE with 5 queued -> current strobe completes; LEVEL=0; no further strobes.
- POC_TIMEOUT_EN, TIMEOUT_CYC=16; printer never drops ready after strobe -> FSM returns to IDLE after 16 cycles in WAIT_BUSY; STATUS bit3=1; no new strobe until CTRL=0x04.

Source files
------------

// File: rtl/poc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// poc_fifo_ctrl -- printer output controller with a DEPTH-entry character FIFO
//
// The CPU writes characters through a four-register file. The block drains
// the FIFO to a printer over a strobe/ready handshake. Two modes are
// available: polling, and level-threshold interrupt. Status bits for
// overflow and timeout are sticky.
//
// Registers (cpu_addr):
//   0 DATA   : write pushes a character; reads 0
//   1 CTRL   : bit0 mode (1 = interrupt), bit1 flush (write-1),
//              bit2 clear ovf/tmo (write-1); reads {0.., mode}
//   2 STATUS : bit0 empty, bit1 full, bit2 ovf, bit3 tmo, bit7 ready (!full)
//   3 LEVEL  : FIFO fill count, zero-extended
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cpu_we     register write strobe (one cycle per access)
//   cpu_re     register read strobe
//   cpu_addr   register select
//   cpu_wdata  write data
//   cpu_rdata  registered read data, valid the cycle after cpu_re
//   irq_n      active-low interrupt request, registered
//   prn_ready  printer idle/ready
//   prn_data   character to printer, stable from load until next load
//   prn_strobe data-valid strobe, high for STROBE_CYC cycles
//
// Optional feature macro: POC_TIMEOUT_EN
//   When defined, a watchdog aborts a handshake that stalls for TIMEOUT_CYC
//   cycles in either wait state. It sets the sticky tmo flag, and new
//   transfers are blocked until the CPU clears tmo.
// ---------------------------------------------------------------------------
module poc_fifo_ctrl #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 8,
   parameter int IRQ_LEVEL   = 2,
   parameter int STROBE_CYC  = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic [1:0]        cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              irq_n,
   input  logic              prn_ready,
   output logic [DATA_W-1:0] prn_data,
   output logic              prn_strobe
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STB_W = $clog2(STROBE_CYC + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] IRQ_CNT  = CNT_W'(IRQ_LEVEL);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYC);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STROBE    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_RDY  = 2'd3
   } state_t;

   state_t state_q, state_d, fsm_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [STB_W-1:0]  strb_cnt_q, strb_cnt_d;
   logic              mode_q, ovf_q, tmo;
   logic              empty, full;
   logic              wr_data, wr_ctrl, flush, clr_err;
   logic              push, pop, ovf_set;
   logic [7:0]        status8;
   logic [DATA_W-1:0] rd_word;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   assign wr_data = cpu_we && (cpu_addr == 2'd0);
   assign wr_ctrl = cpu_we && (cpu_addr == 2'd1);
   assign flush   = wr_ctrl && cpu_wdata[1];
   assign clr_err = wr_ctrl && cpu_wdata[2];

   // A pop in the same cycle frees a slot, so a write to a full FIFO is
   // still accepted then. A flush discards a write in the same cycle.
   assign push    = wr_data && (!full || pop) && !flush;
   assign ovf_set = wr_data && full && !pop;

`ifdef POC_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_q;
   logic             tmo_expire;

   assign tmo = tmo_q;

   // The watchdog counts cycles spent in a wait state without a transition.
   // It restarts whenever the FSM changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         if ((state_d != state_q) ||
             !((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_RDY)))
            tmo_cnt_q <= '0;
         else
            tmo_cnt_q <= tmo_cnt_q + 1'b1;

         if (tmo_expire)
            tmo_q <= 1'b1;
         else if (clr_err)
            tmo_q <= 1'b0;
      end
   end
`else
   // Without the watchdog the timeout flag is tied off. The comparison keeps
   // the limit parameter referenced, and it is false for every legal value.
   assign tmo = (TIMEOUT_CYC < 1);
`endif

   // Printer handshake next-state logic. A new character is only started
   // from IDLE, and never while a timeout is pending.
   always_comb begin
      fsm_next   = state_q;
      strb_cnt_d = strb_cnt_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty && prn_ready && !tmo) begin
               pop        = 1'b1;
               fsm_next   = ST_STROBE;
               strb_cnt_d = STB_W'(1);
            end
         end
         ST_STROBE: begin
            if (strb_cnt_q == STB_LAST)
               fsm_next = ST_WAIT_BUSY;
            else
               strb_cnt_d = strb_cnt_q + 1'b1;
         end
         ST_WAIT_BUSY: begin
            if (!prn_ready)
               fsm_next = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            if (prn_ready)
               fsm_next = ST_IDLE;
         end
         default: fsm_next = ST_IDLE;
      endcase

      state_d = fsm_next;
`ifdef POC_TIMEOUT_EN
      tmo_expire = 1'b0;
      if (((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_RDY)) &&
          (fsm_next == state_q) && (tmo_cnt_q == TMO_LAST)) begin
         tmo_expire = 1'b1;
         state_d    = ST_IDLE;
      end
`endif
   end

   // Strobe is registered from the next state. It rises on the same edge as
   // the pop, and reset drops it asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         strb_cnt_q <= '0;
         prn_strobe <= 1'b0;
         prn_data   <= '0;
      end else begin
         state_q    <= state_d;
         strb_cnt_q <= strb_cnt_d;
         prn_strobe <= (state_d == ST_STROBE);
         if (pop)
            prn_data <= mem[rd_ptr_q];
      end
   end

   // Character storage has no reset. Occupancy is tracked by the count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= cpu_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two. A flush wins
   // over any push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Mode bit and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_ctrl)
            mode_q <= cpu_wdata[0];
         if (ovf_set)
            ovf_q <= 1'b1;
         else if (clr_err)
            ovf_q <= 1'b0;
      end
   end

   assign status8 = {!full, 3'b000, tmo, ovf_q, full, empty};

   always_comb begin
      rd_word = '0;
      case (cpu_addr)
         2'd1:    rd_word = DATA_W'(mode_q);
         2'd2:    rd_word = DATA_W'(status8);
         2'd3:    rd_word = DATA_W'(count_q);
         default: rd_word = '0;
      endcase
   end

   // Read data holds between reads. A read that collides with a write is
   // ignored, so the write takes effect and the old data stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cpu_rdata <= '0;
      else if (cpu_re && !cpu_we)
         cpu_rdata <= rd_word;
   end

   // The interrupt asks for more data while the printer side is idle at a
   // low fill level. A pending timeout also raises it in interrupt mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq_n <= 1'b1;
      else
         irq_n <= !(mode_q && (((state_q == ST_IDLE) && (count_q <= IRQ_CNT)) || tmo));
   end

endmodule
